// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DataMemory port between the pipeline MEM stage
// and a loader/debug master.
// Every access has a grant cycle followed by WAIT_STATES extra cycles.
// A starvation counter forces a loader grant after STARVE_LIMIT consecutive
// pipeline grants made while the loader was waiting.
//
// Ports:
//   clk, reset         rising-edge clock; asynchronous active-low reset
//   p_req/p_addr/p_wdata/p_size/p_rw
//                      pipeline request and access attributes
//   p_rdata            pipeline read data (m_rdata passed straight through)
//   p_stall            pipeline must hold MEM and freeze fetch/decode
//   l_req/l_addr/l_wdata/l_size/l_rw
//                      loader request, held until l_done
//   l_gnt              one-cycle pulse in the loader grant cycle
//   l_done             registered pulse, the cycle after loader completion
//   l_rdata            registered loader read data, held until the next loader read
//   m_addr/m_wdata/m_size/m_rw/m_en, m_rdata
//                      DataMemory port
//   owner              current or last grantee (0 = pipeline, 1 = loader)
module dmem_arbiter #(
   parameter int unsigned WAIT_STATES  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_req,
   input  logic [31:0] p_addr,
   input  logic [31:0] p_wdata,
   input  logic [1:0]  p_size,
   input  logic        p_rw,
   output logic [31:0] p_rdata,
   output logic        p_stall,
   input  logic        l_req,
   input  logic [31:0] l_addr,
   input  logic [31:0] l_wdata,
   input  logic [1:0]  l_size,
   input  logic        l_rw,
   output logic        l_gnt,
   output logic        l_done,
   output logic [31:0] l_rdata,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [1:0]  m_size,
   output logic        m_rw,
   output logic        m_en,
   input  logic [31:0] m_rdata,
   output logic        owner
);

   localparam logic [2:0] WS = 3'(WAIT_STATES);
   localparam logic [3:0] SL = 4'(STARVE_LIMIT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic [3:0] starve;
   logic       owner_q;
   logic       grant, win, active, cur, complete;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      grant     = 1'b0;
      win       = 1'b0;
      active    = 1'b0;
      cur       = owner_q;
      complete  = 1'b0;
      unique case (state)
         IDLE: begin
            // Gated by reset so no combinational grant leaks out while held in reset.
            if (reset) begin
               if (l_req && (!p_req || starve == SL)) begin
                  grant = 1'b1;
                  win   = 1'b1;
               end else if (p_req) begin
                  grant = 1'b1;
               end
            end
            if (grant) begin
               active = 1'b1;
               cur    = win;
               if (WAIT_STATES == 0) begin
                  complete = 1'b1;
               end else begin
                  state_nxt = BUSY;
                  cnt_nxt   = 3'd1;
               end
            end
         end
         BUSY: begin
            active  = 1'b1;
            cnt_nxt = cnt + 3'd1;
            if (cnt == WS) begin
               complete  = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      m_size  = '0;
      m_rw    = 1'b0;
      m_en    = active;
      if (active) begin
         m_addr  = cur ? l_addr  : p_addr;
         m_wdata = cur ? l_wdata : p_wdata;
         m_size  = cur ? l_size  : p_size;
         m_rw    = cur ? l_rw    : p_rw;
      end
   end

   // During an access cur is the live grantee; otherwise it is the last one.
   assign owner   = cur;
   assign l_gnt   = grant && win;
   assign p_stall = p_req && !(active && !cur && complete);
   assign p_rdata = m_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         starve  <= '0;
         owner_q <= 1'b0;
         l_done  <= 1'b0;
         l_rdata <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         l_done <= active && complete && cur;
         if (grant)
            owner_q <= win;
         if (active && complete && cur && !l_rw)
            l_rdata <= m_rdata;
         if (!l_req || (grant && win))
            starve <= '0;
         else if (grant && starve != SL)
            starve <= starve + 4'd1;
      end
   end

endmodule
